// File: rtl/screen_scanner.sv
// rtl/screen_scanner.sv - framebuffer scan-out: fetches 256 bytes and streams them as raster-ordered pixels
module screen_scanner #(
  parameter logic [11:0] BASE_ADDR   = 12'h100,
  parameter int          WIDTH_BYTES = 8,
  parameter int          HEIGHT      = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        mem_read,
  output logic [11:0] mem_read_idx,
  input  logic [7:0]  mem_read_byte,
  input  logic        mem_read_ack,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_data,
  output logic [5:0]  pix_x,
  output logic [4:0]  pix_y,
  output logic        pix_eol,
  output logic        pix_last
);
  localparam logic [8:0] FRAME_BYTES = 9'(WIDTH_BYTES * HEIGHT);
  localparam logic [5:0] X_LAST      = 6'(WIDTH_BYTES * 8 - 1);
  localparam logic [4:0] Y_LAST      = 5'(HEIGHT - 1);

  logic       busy_q;
  logic       req_q;
  logic       frame_done_q;
  logic [8:0] fidx_q;
  logic [8:0] fidx_next;
  logic [7:0] fifo_mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] fifo_cnt;
  logic [7:0] sh_data;
  logic [3:0] sh_cnt;
  logic [5:0] x_q;
  logic [4:0] y_q;

  logic start_acc;
  logic ack_hit;
  logic accept;
  logic last_acc;
  logic load;
  logic launch;

  always_comb begin
    start_acc = start & ~busy_q;
    ack_hit   = req_q & mem_read_ack;
    pix_valid = (sh_cnt != 4'd0);
    pix_data  = pix_valid & sh_data[7];
    accept    = pix_valid & pix_ready;
    pix_eol   = pix_valid & (x_q == X_LAST);
    pix_last  = pix_eol & (y_q == Y_LAST);
    last_acc  = accept & pix_last;
    // Refill on the cycle the final bit leaves so the stream has no gap between bytes.
    load      = (fifo_cnt != 2'd0) && ((sh_cnt == 4'd0) || ((sh_cnt == 4'd1) && accept));
    fidx_next = fidx_q + {8'd0, ack_hit};
    // In-flight counts against FIFO space, so an ack can never find the FIFO full.
    launch    = busy_q && (!req_q || ack_hit) && (fidx_next < FRAME_BYTES) &&
                (({1'b0, fifo_cnt} + {2'b0, req_q}) < 3'd2);
    mem_read     = req_q & ~mem_read_ack;
    mem_read_idx = mem_read ? (BASE_ADDR + {3'b000, fidx_q}) : 12'd0;
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign pix_x      = x_q;
  assign pix_y      = y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      req_q        <= 1'b0;
      frame_done_q <= 1'b0;
      fidx_q       <= 9'd0;
      fifo_mem[0]  <= 8'd0;
      fifo_mem[1]  <= 8'd0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_cnt     <= 2'd0;
      sh_data      <= 8'd0;
      sh_cnt       <= 4'd0;
      x_q          <= 6'd0;
      y_q          <= 5'd0;
    end else begin
      frame_done_q <= last_acc;
      if (start_acc) begin
        busy_q   <= 1'b1;
        req_q    <= 1'b1;
        fidx_q   <= 9'd0;
        wr_ptr   <= 1'b0;
        rd_ptr   <= 1'b0;
        fifo_cnt <= 2'd0;
        sh_data  <= 8'd0;
        sh_cnt   <= 4'd0;
        x_q      <= 6'd0;
        y_q      <= 5'd0;
      end else begin
        if (last_acc) begin
          busy_q <= 1'b0;
        end
        req_q <= launch | (req_q & ~mem_read_ack);
        if (ack_hit) begin
          fifo_mem[wr_ptr] <= mem_read_byte;
          wr_ptr           <= ~wr_ptr;
          fidx_q           <= fidx_next;
        end
        if (load) begin
          rd_ptr <= ~rd_ptr;
        end
        fifo_cnt <= fifo_cnt + {1'b0, ack_hit} - {1'b0, load};

        if (load) begin
          sh_data <= fifo_mem[rd_ptr];
          sh_cnt  <= 4'd8;
        end else if (accept) begin
          sh_data <= {sh_data[6:0], 1'b0};
          sh_cnt  <= sh_cnt - 4'd1;
        end

        if (accept) begin
          if (x_q == X_LAST) begin
            x_q <= 6'd0;
            y_q <= (y_q == Y_LAST) ? 5'd0 : y_q + 5'd1;
          end else begin
            x_q <= x_q + 6'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_screen_scanner.sv
// tb/tb_screen_scanner.sv - scoreboard bench for screen_scanner
module tb_screen_scanner;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic        mem_read;
  logic [11:0] mem_read_idx;
  logic [7:0]  mem_read_byte;
  logic        mem_read_ack;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_data;
  logic [5:0]  pix_x;
  logic [4:0]  pix_y;
  logic        pix_eol;
  logic        pix_last;

  screen_scanner dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
    .mem_read(mem_read), .mem_read_idx(mem_read_idx), .mem_read_byte(mem_read_byte),
    .mem_read_ack(mem_read_ack), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_eol(pix_eol), .pix_last(pix_last)
  );

  always #5 clk = ~clk;

  logic [7:0]  fb [0:4095];
  logic [13:0] exp_q [$];
  logic [11:0] addr_q [$];
  logic [11:0] held_idx;
  int n_checks = 0;
  int n_pass = 0;
  int resp_lat = 1;
  int resp_wait = 0;
  int ack_count = 0;
  int idx_bad = 0;
  int drop_bad = 0;
  int pix_cnt, lit_cnt, eol_cnt;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_read_ack) mem_read_ack = 1'b0;
      #1;
      if (!rst_n) begin
        resp_wait = 0;
      end else if (mem_read) begin
        if (resp_wait == 0) held_idx = mem_read_idx;
        else if (mem_read_idx !== held_idx) idx_bad++;
        resp_wait++;
        if (resp_wait > resp_lat) begin
          addr_q.push_back(mem_read_idx);
          mem_read_byte = fb[mem_read_idx];
          mem_read_ack  = 1'b1;
          ack_count++;
          resp_wait = 0;
          #1;
          if (mem_read !== 1'b0) drop_bad++;
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_fb(input int mode);
    for (int i = 0; i < 4096; i++) fb[i] = (mode == 2) ? 8'($urandom) : 8'h00;
    if (mode == 1) begin
      fb[12'h100] = 8'h81;
      fb[12'h107] = 8'h01;
      fb[12'h1FF] = 8'h01;
    end
  endtask

  task automatic load_expected();
    logic [7:0] b;
    logic [5:0] x;
    logic [4:0] y;
    for (int i = 0; i < 256; i++) begin
      b = fb[256 + i];
      for (int k = 7; k >= 0; k--) begin
        x = 6'((i % 8) * 8 + (7 - k));
        y = 5'(i / 8);
        exp_q.push_back({b[k], x, y, x == 6'd63, (x == 6'd63) && (y == 5'd31)});
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input string name, input int rdy_pct, input int abort_at,
                           input int start_at, input bit chain, output int done_cyc);
    int cyc, ack_base, occ, max_occ;
    bit prev_stall, extra_done;
    logic [13:0] prev_pix, obs, exp_pix;
    cyc = 1; ack_base = ack_count; max_occ = 0; done_cyc = -1;
    prev_stall = 0; extra_done = 0; prev_pix = '0;
    pix_cnt = 0; lit_cnt = 0; eol_cnt = 0; idx_bad = 0; drop_bad = 0;
    addr_q.delete();
    while (cyc < 20000) begin
      if (abort_at >= 0 && pix_cnt >= abort_at) return;
      if (frame_done) begin
        done_cyc = cyc;
        break;
      end
      obs = {pix_data, pix_x, pix_y, pix_eol, pix_last};
      if (prev_stall) begin
        n_checks++;
        if (!(pix_valid === 1'b1 && obs === prev_pix))
          $display("FAIL %s hold: valid=%b pix=%h required valid=1 pix=%h", name, pix_valid, obs, prev_pix);
        else n_pass++;
      end
      if (start_at >= 0 && pix_cnt == start_at && !extra_done) begin
        start = 1'b1;
        extra_done = 1;
      end else begin
        start = 1'b0;
      end
      pix_ready = (int'($urandom_range(99, 0)) < rdy_pct);
      occ = (ack_count - ack_base) - pix_cnt / 8;
      if (occ > max_occ) max_occ = occ;
      if (pix_valid && pix_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s extra pixel: got %h, required none", name, obs);
        end else begin
          exp_pix = exp_q.pop_front();
          if (obs !== exp_pix)
            $display("FAIL %s pixel %0d: got %h required %h", name, pix_cnt, obs, exp_pix);
          else n_pass++;
        end
        pix_cnt++;
        if (pix_data) lit_cnt++;
        if (pix_eol) eol_cnt++;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_pix = obs;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (done_cyc < 0) begin
      $display("FAIL %s timeout: frame_done not seen, pixels=%0d required 2048", name, pix_cnt);
      return;
    end
    n_pass++;
    n_checks++;
    if (pix_cnt !== 2048 || exp_q.size() != 0)
      $display("FAIL %s count: pixels=%0d left=%0d required 2048/0", name, pix_cnt, exp_q.size());
    else n_pass++;
    n_checks++;
    if (addr_q.size() != 256) begin
      $display("FAIL %s reads: got %0d required 256", name, addr_q.size());
    end else begin
      n_pass++;
      for (int i = 0; i < 256; i++) begin
        n_checks++;
        if (addr_q[i] !== 12'(32'h100 + i))
          $display("FAIL %s read %0d: addr %h required %h", name, i, addr_q[i], 12'(32'h100 + i));
        else n_pass++;
      end
    end
    n_checks++;
    if (idx_bad != 0 || drop_bad != 0)
      $display("FAIL %s request hold: idx_changes=%0d drops_missed=%0d required 0/0", name, idx_bad, drop_bad);
    else n_pass++;
    n_checks++;
    if (max_occ > 3) $display("FAIL %s buffering: %0d bytes required <= 3", name, max_occ);
    else n_pass++;
    if (chain) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (frame_done !== 1'b0 || busy !== chain)
      $display("FAIL %s after frame: frame_done=%b busy=%b required 0/%b", name, frame_done, busy, chain);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; pix_ready = 1'b0; mem_read_ack = 1'b0; mem_read_byte = 8'h00;
    fill_fb(0);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, frame_done, mem_read, mem_read_idx, pix_valid, pix_data, pix_x, pix_y, pix_eol, pix_last} !== 30'd0)
      $display("FAIL reset outputs: got %h required 0",
               {busy, frame_done, mem_read, mem_read_idx, pix_valid, pix_data, pix_x, pix_y, pix_eol, pix_last});
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || mem_read !== 1'b0 || pix_valid !== 1'b0)
      $display("FAIL reset idle: busy=%b mem_read=%b valid=%b required 0", busy, mem_read, pix_valid);
    else n_pass++;
  endtask

  task automatic test_blank_frame_timing();
    int dc;
    fill_fb(0);
    load_expected();
    pulse_start();
    run_frame("blank", 100, -1, -1, 0, dc);
    n_checks++;
    if (dc !== 2052) $display("FAIL blank frame_done cycle: got %0d required 2052", dc);
    else n_pass++;
    n_checks++;
    if (lit_cnt !== 0) $display("FAIL blank lit: got %0d required 0", lit_cnt);
    else n_pass++;
  endtask

  task automatic test_sparse_pattern();
    int dc;
    fill_fb(1);
    load_expected();
    pulse_start();
    run_frame("sparse", 100, -1, -1, 0, dc);
    n_checks++;
    if (lit_cnt !== 4 || eol_cnt !== 32)
      $display("FAIL sparse lit/eol: got %0d/%0d required 4/32", lit_cnt, eol_cnt);
    else n_pass++;
  endtask

  task automatic test_random_backpressure();
    int dc;
    fill_fb(2);
    load_expected();
    pulse_start();
    run_frame("random_ready", 50, -1, -1, 0, dc);
  endtask

  task automatic test_slow_responder();
    int dc;
    fill_fb(2);
    resp_lat = 10;
    load_expected();
    pulse_start();
    run_frame("slow_ack", 100, -1, -1, 0, dc);
    resp_lat = 1;
  endtask

  task automatic test_reset_mid_frame();
    int dc;
    fill_fb(2);
    load_expected();
    pulse_start();
    run_frame("pre_reset", 100, 500, -1, 0, dc);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, frame_done, mem_read, mem_read_idx, pix_valid, pix_data, pix_x, pix_y, pix_eol, pix_last} !== 30'd0)
      $display("FAIL async reset outputs: got %h required 0",
               {busy, frame_done, mem_read, mem_read_idx, pix_valid, pix_data, pix_x, pix_y, pix_eol, pix_last});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem_read_ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || mem_read !== 1'b0 || pix_valid !== 1'b0)
      $display("FAIL stray ack: busy=%b mem_read=%b valid=%b required 0", busy, mem_read, pix_valid);
    else n_pass++;
    exp_q.delete();
    load_expected();
    pulse_start();
    run_frame("post_reset", 100, -1, -1, 0, dc);
  endtask

  task automatic test_start_ignored_and_back_to_back();
    int dc;
    fill_fb(2);
    load_expected();
    pulse_start();
    run_frame("start_ignored", 100, -1, 1000, 1, dc);
    load_expected();
    run_frame("back_to_back", 100, -1, -1, 0, dc);
  endtask

  initial begin
    test_reset();
    test_blank_frame_timing();
    test_sparse_pattern();
    test_random_backpressure();
    test_slow_responder();
    test_reset_mid_frame();
    test_start_ignored_and_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/screen_scanner.md
# screen_scanner

Framebuffer scan-out engine: the reader for the sprite-drawing engine's writes. On a `start` pulse it reads the 64x32 monochrome framebuffer (256 bytes at `BASE_ADDR`) from shared memory. It uses the same `mem_read`/`mem_read_ack` request protocol as the other memory clients, and emits the frame as a raster-ordered 1-bit pixel stream with a valid/ready handshake toward the display driver. A small byte FIFO decouples memory fetch latency from pixel back-pressure.

## Interface
- `BASE_ADDR`, 12'h100, framebuffer start address.
- `WIDTH_BYTES`, 8, bytes per row (64 pixels).
- `HEIGHT`, 32, rows per frame.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle frame request; ignored while `busy`.
- `busy`  out  1  high from the edge that samples `start` through the edge that retires the last pixel.
- `frame_done`  out  1  one-cycle pulse after the last pixel handshake.
- `mem_read`  out  1  read request.
- `mem_read_idx`  out  12  read address.
- `mem_read_byte`  in  8  read data, valid in the `mem_read_ack` cycle.
- `mem_read_ack`  in  1  responder acknowledge.
- `pix_valid`  out  1  pixel available.
- `pix_ready`  in  1  consumer accepts pixel.
- `pix_data`  out  1  pixel value, 1 = lit.
- `pix_x`  out  6  column of current pixel.
- `pix_y`  out  5  row of current pixel.
- `pix_eol`  out  1  current pixel is x = 63.
- `pix_last`  out  1  current pixel is (63,31).

## Operation
- Reset values: all outputs 0. Fetch counter, FIFO, shifter and coordinates are cleared.
- Fetch engine:
  - Byte counter `fidx` runs 0..255. Address = `BASE_ADDR + fidx`, mod 2^12.
  - A request is launched only when `busy`, `fidx` < 256, and FIFO occupancy + in-flight < 2 (FIFO depth 2).
  - While waiting: `mem_read` = 1 and `mem_read_idx` is held constant, as long as `mem_read_ack` = 0.
  - `mem_read` is forced 0 combinationally in the ack cycle. `mem_read_idx` is 0 whenever `mem_read` = 0.
  - On the ack edge: the byte is pushed to the FIFO and `fidx` increments.
- Shifter:
  - Loads from the FIFO when it is empty, or when its 8th bit is being accepted in the same cycle. Load and FIFO push may coincide.
  - Shifts out MSB first: bit 7 maps to x = 8*(fidx mod 8), bit 0 maps to x + 7.
  - `pix_x`/`pix_y` advance on each `pix_valid & pix_ready`. x wraps 63→0 with y++.
- `pix_data`, `pix_x`, `pix_y`, `pix_eol` and `pix_last` are stable while `pix_valid & !pix_ready`.
- End of frame:
  - Accepting the pixel with `pix_last` clears `busy` on that edge and pulses `frame_done` for the next cycle.
  - `start` in the `frame_done` cycle is accepted.
- `start` while `busy`: no effect, with no restart and no counter disturbance.
- Reset mid-frame: all outputs drop to 0 immediately, including `mem_read` with its outstanding request, regardless of clock. The next `start` begins at address `BASE_ADDR`, pixel (0,0).
- The responder may assert `mem_read_ack` no sooner than the cycle after `mem_read` rises. A late `mem_read_ack` arriving after a reset is ignored.

## Timing
- Edge E0 samples `start` → `mem_read` high in cycle 1.
- With a 1-cycle responder: ack in cycle 2, FIFO write at E2, shifter load at E3, first `pix_valid` in cycle 4.
- Steady state with `pix_ready` = 1 and ack latency ≤ 6 cycles: zero bubbles. That gives 2048 pixels on 2048 consecutive cycles, with `frame_done` in the cycle after the last.
- Exactly 256 read handshakes per frame, in strictly ascending address order.
- `pix_valid`, once high, stays high until the handshake, except at frame end.

## Test plan
- All-zero framebuffer, `pix_ready` = 1, 1-cycle responder → 2048 pixels with `pix_data` = 0 and one `pix_last` at (63,31). `frame_done` pulses exactly once, 2052 cycles after the `start` edge. Reads cover 0x100..0x1FF ascending.
- mem[0x100] = 0x81, mem[0x107] = 0x01, mem[0x1FF] = 0x01 → lit pixels only at (0,0), (7,0), (63,0) and (63,31). `pix_eol` is high at every x = 63.
- Random `pix_ready` (50 %) with a random framebuffer → stream identical to the golden model. Outputs are held under stall, and at most 2 bytes are buffered plus 1 in flight.
- Responder ack latency 10 cycles → correct stream. `mem_read_idx` is constant from request to ack, and `mem_read` drops in the ack cycle.
- `rst_n` low after pixel 500 → all outputs 0 asynchronously. A subsequent `start` begins at 0x100 / (0,0) with a full correct frame.
- `start` pulsed at pixel 1000 → ignored. `start` in the `frame_done` cycle → a second full frame follows.
